// File: rtl/traffic_light_monitor_pkg.sv
// Shared types for the traffic light monitor: phase and fault-code encodings,
// lamp patterns and the legal phase-step rule.
package tlm_pkg;

    typedef enum logic [2:0] {
        PH_NONE  = 3'd0,
        A_G      = 3'd1,
        A_Y      = 3'd2,
        B_G      = 3'd3,
        B_Y      = 3'd4,
        W_G      = 3'd5,
        W_R      = 3'd6,
        PH_MAINT = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_CONFLICT = 3'd1,
        FC_ILLEGAL  = 3'd2,
        FC_SEQUENCE = 3'd3,
        FC_SHORT    = 3'd4,
        FC_STUCK    = 3'd5
    } fault_code_e;

    // Lamp vector bit order: {Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw}
    localparam logic [7:0] LAMP_DARK   = 8'b0000_0000;
    localparam logic [7:0] LAMP_A_G    = 8'b1000_0101;
    localparam logic [7:0] LAMP_A_Y    = 8'b0100_0101;
    localparam logic [7:0] LAMP_B_G    = 8'b0011_0001;
    localparam logic [7:0] LAMP_B_Y    = 8'b0010_1001;
    localparam logic [7:0] LAMP_W_G    = 8'b0010_0110;
    localparam logic [7:0] LAMP_W_R    = 8'b0010_0100;
    localparam logic [7:0] LAMP_W_R_RW = 8'b0010_0101;

    function automatic logic legal_step(input phase_e from_ph, input phase_e to_ph);
        logic ok;
        case (from_ph)
            PH_NONE:  ok = 1'b1;
            A_G:      ok = (to_ph == A_Y);
            A_Y:      ok = (to_ph == B_G);
            B_G:      ok = (to_ph == B_Y);
            B_Y:      ok = (to_ph == W_G);
            W_G:      ok = (to_ph == W_R);
            W_R:      ok = (to_ph == A_G);
            PH_MAINT: ok = (to_ph == A_G);
            default:  ok = 1'b0;
        endcase
        return ok || (to_ph == PH_MAINT);
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between the intersection controller (master) and this monitor
// (slave); force_flash travels back to the controller.
interface traffic_light_monitor_if;
    logic Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw;
    logic MAINT;
    logic tick;
    logic force_flash;

    modport master (
        output Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw, MAINT, tick,
        input  force_flash
    );

    modport slave (
        input  Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw, MAINT, tick,
        output force_flash
    );
endinterface

// File: rtl/traffic_light_monitor_lamp_decode.sv
// Combinational decode of the registered lamp pattern into a phase, with
// illegal-pattern and conflicting-go detection.
module tlm_lamp_decode
    import tlm_pkg::*;
(
    input  logic [7:0] lamps_i,
    input  logic       maint_i,
    output phase_e     phase_o,
    output logic       illegal_o,
    output logic       conflict_o
);

    logic go_a, go_b, go_w;

    always_comb begin
        go_a       = lamps_i[7] | lamps_i[6];
        go_b       = lamps_i[4] | lamps_i[3];
        go_w       = lamps_i[1];
        conflict_o = (go_a & go_b) | (go_a & go_w) | (go_b & go_w);
        phase_o    = PH_NONE;
        illegal_o  = 1'b0;

        if (maint_i) begin
            if (go_a | go_b | go_w) illegal_o = 1'b1;
            else                    phase_o   = PH_MAINT;
        end else begin
            case (lamps_i)
                LAMP_A_G:              phase_o = A_G;
                LAMP_A_Y:              phase_o = A_Y;
                LAMP_B_G:              phase_o = B_G;
                LAMP_B_Y:              phase_o = B_Y;
                LAMP_W_G:              phase_o = W_G;
                LAMP_W_R, LAMP_W_R_RW: phase_o = W_R;
                LAMP_DARK:             phase_o = PH_MAINT;
                default:               illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Independent conflict/sequence monitor on the controller's lamp bus; latches a
// sticky fault with its first cause and requests all-red flash.
module traffic_light_monitor
    import tlm_pkg::*;
#(
    parameter int unsigned MIN_A_G     = 3,
    parameter int unsigned MIN_A_Y     = 2,
    parameter int unsigned MIN_B_G     = 3,
    parameter int unsigned MIN_B_Y     = 1,
    parameter int unsigned MIN_W_G     = 2,
    parameter int unsigned MIN_W_R     = 11,
    parameter int unsigned MAX_DWELL_T = 32
)
(
    input  logic                    clk,
    input  logic                    reset,
    traffic_light_monitor_if.slave  bus,
    input  logic                    clear_fault,
    output logic                    fault,
    output logic [2:0]              fault_code,
    output logic [2:0]              phase,
    output logic [7:0]              dwell,
    output logic                    cycle_done
);

    localparam logic [7:0] STUCK_PRE = 8'(MAX_DWELL_T - 1);

    logic [7:0]  lamps_q;
    logic        maint_q, tick_q;
    phase_e      dec_phase;
    logic        dec_illegal, dec_conflict;

    phase_e      phase_q, phase_d;
    logic [7:0]  dwell_q, dwell_d;
    logic        first_q, first_d;
    logic        fault_q, fault_d;
    fault_code_e code_q, code_d, new_code;
    logic        done_q, done_d;

    logic        change, seq_err, short_err, stuck_err, real_phase;
    logic [7:0]  min_dwell;

    always_ff @(posedge clk) begin
        if (reset) begin
            lamps_q <= '0;
            maint_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            lamps_q <= {bus.Ga, bus.Ya, bus.Ra, bus.Gb, bus.Yb, bus.Rb, bus.Gw, bus.Rw};
            maint_q <= bus.MAINT;
            tick_q  <= bus.tick;
        end
    end

    tlm_lamp_decode u_decode (
        .lamps_i    (lamps_q),
        .maint_i    (maint_q),
        .phase_o    (dec_phase),
        .illegal_o  (dec_illegal),
        .conflict_o (dec_conflict)
    );

    always_comb begin
        case (phase_q)
            A_G:     min_dwell = 8'(MIN_A_G);
            A_Y:     min_dwell = 8'(MIN_A_Y);
            B_G:     min_dwell = 8'(MIN_B_G);
            B_Y:     min_dwell = 8'(MIN_B_Y);
            W_G:     min_dwell = 8'(MIN_W_G);
            W_R:     min_dwell = 8'(MIN_W_R);
            default: min_dwell = '0;
        endcase

        real_phase = (phase_q != PH_NONE) && (phase_q != PH_MAINT);
        change     = !dec_illegal && !dec_conflict && (dec_phase != phase_q);
        seq_err    = change && !legal_step(phase_q, dec_phase);
        short_err  = change && !first_q && real_phase && (dwell_q < min_dwell);
        // Fires once, on the tick that would carry dwell onto the limit, so a clear can stick.
        stuck_err  = !change && real_phase && tick_q && (dwell_q == STUCK_PRE);

        if      (dec_conflict) new_code = FC_CONFLICT;
        else if (dec_illegal)  new_code = FC_ILLEGAL;
        else if (seq_err)      new_code = FC_SEQUENCE;
        else if (short_err)    new_code = FC_SHORT;
        else if (stuck_err)    new_code = FC_STUCK;
        else                   new_code = FC_NONE;

        phase_d = change ? dec_phase : phase_q;
        first_d = change ? 1'b0 : first_q;
        done_d  = change && (phase_q == W_R) && (dec_phase == A_G);

        if (change)                          dwell_d = '0;
        else if (tick_q && dwell_q != 8'hFF) dwell_d = dwell_q + 8'd1;
        else                                 dwell_d = dwell_q;

        fault_d = fault_q;
        code_d  = code_q;
        if (clear_fault) begin
            fault_d = 1'b0;
            code_d  = FC_NONE;
        end
        if (new_code != FC_NONE && !fault_d) begin
            fault_d = 1'b1;
            code_d  = new_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_NONE;
            dwell_q <= '0;
            first_q <= 1'b1;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            dwell_q <= dwell_d;
            first_q <= first_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    assign fault           = fault_q;
    assign fault_code      = code_q;
    assign phase           = phase_q;
    assign dwell           = dwell_q;
    assign cycle_done      = done_q;
    assign bus.force_flash = fault_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: legal cycles, each fault class,
// maintenance entry/exit, clear and mid-phase reset.
module tb_traffic_light_monitor;

    // {Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw}
    localparam logic [7:0] P_AG   = 8'b1000_0101;
    localparam logic [7:0] P_AY   = 8'b0100_0101;
    localparam logic [7:0] P_BG   = 8'b0011_0001;
    localparam logic [7:0] P_BY   = 8'b0010_1001;
    localparam logic [7:0] P_WG   = 8'b0010_0110;
    localparam logic [7:0] P_WR   = 8'b0010_0101;
    localparam logic [7:0] P_RED  = 8'b0010_0101;
    localparam logic [7:0] P_DARK = 8'b0000_0000;
    localparam logic [7:0] P_CONF = 8'b1001_0101;

    logic       clk = 1'b0;
    logic       reset, clear_fault;
    logic       fault, cycle_done;
    logic [2:0] fault_code, phase;
    logic [7:0] dwell;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    always #5 clk = ~clk;

    traffic_light_monitor_if bus ();

    traffic_light_monitor #(
        .MIN_A_G(3), .MIN_A_Y(2), .MIN_B_G(3), .MIN_B_Y(1),
        .MIN_W_G(2), .MIN_W_R(11), .MAX_DWELL_T(32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .clear_fault (clear_fault),
        .fault       (fault),
        .fault_code  (fault_code),
        .phase       (phase),
        .dwell       (dwell),
        .cycle_done  (cycle_done)
    );

    always @(posedge clk) if (!reset && cycle_done) n_done++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] pat, input logic m);
        {bus.Ga, bus.Ya, bus.Ra, bus.Gb, bus.Yb, bus.Rb, bus.Gw, bus.Rw} = pat;
        bus.MAINT = m;
    endtask

    // Hold a pattern for n ticks (one tick every 4 clk), checking the decoded phase early on.
    task automatic hold(input string tag, input logic [7:0] pat, input logic m,
                        input logic [2:0] exp_ph, input int n);
        drive(pat, m);
        for (int i = 0; i < n; i++) begin
            repeat (2) @(negedge clk);
            if (i == 0) check_eq(tag, 32'(phase), 32'(exp_ph));
            @(negedge clk);
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
        end
    endtask

    task automatic run_cycle();
        hold("ph_AG", P_AG, 1'b0, 3'd1, 3);
        hold("ph_AY", P_AY, 1'b0, 3'd2, 2);
        hold("ph_BG", P_BG, 1'b0, 3'd3, 3);
        hold("ph_BY", P_BY, 1'b0, 3'd4, 1);
        hold("ph_WG", P_WG, 1'b0, 3'd5, 2);
        hold("ph_WR", P_WR, 1'b0, 3'd6, 11);
    endtask

    task automatic pulse_clear(input string tag);
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        check_eq({tag, "_fault"}, 32'(fault), 32'd0);
        check_eq({tag, "_code"}, 32'(fault_code), 32'd0);
        check_eq({tag, "_ff"}, 32'(bus.force_flash), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        clear_fault = 1'b0;
        bus.tick = 1'b0;
        drive(P_AG, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_code", 32'(fault_code), 32'd0);
        check_eq("rst_ff", 32'(bus.force_flash), 32'd0);
        check_eq("rst_phase", 32'(phase), 32'd0);
        check_eq("rst_dwell", 32'(dwell), 32'd0);
        check_eq("rst_done", 32'(cycle_done), 32'd0);
        reset = 1'b0;

        // Three legal cycles closing into A_G
        repeat (3) run_cycle();
        hold("ph_AG_end", P_AG, 1'b0, 3'd1, 3);
        check_eq("cycle_fault", 32'(fault), 32'd0);
        check_eq("cycle_done_cnt", 32'(n_done), 32'd3);

        // Conflicting greens for one clk
        drive(P_CONF, 1'b0);
        @(negedge clk);
        drive(P_AG, 1'b0);
        @(negedge clk);
        check_eq("conf_fault", 32'(fault), 32'd1);
        check_eq("conf_code", 32'(fault_code), 32'd1);
        check_eq("conf_ff", 32'(bus.force_flash), 32'd1);
        check_eq("conf_phase", 32'(phase), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("conf_sticky", 32'(fault), 32'd1);
        pulse_clear("conf_clr");

        // Short A_G dwell (2 of 3 ticks)
        hold("s_AY", P_AY, 1'b0, 3'd2, 2);
        hold("s_BG", P_BG, 1'b0, 3'd3, 3);
        hold("s_BY", P_BY, 1'b0, 3'd4, 1);
        hold("s_WG", P_WG, 1'b0, 3'd5, 2);
        hold("s_WR", P_WR, 1'b0, 3'd6, 11);
        hold("s_AG", P_AG, 1'b0, 3'd1, 2);
        drive(P_AY, 1'b0);
        @(negedge clk);
        check_eq("short_pre", 32'(fault), 32'd0);
        @(negedge clk);
        check_eq("short_fault", 32'(fault), 32'd1);
        check_eq("short_code", 32'(fault_code), 32'd4);
        check_eq("short_phase", 32'(phase), 32'd2);
        hold("s_AY2", P_AY, 1'b0, 3'd2, 2);
        pulse_clear("short_clr");

        // A_G straight to B_G
        hold("q_BG", P_BG, 1'b0, 3'd3, 3);
        hold("q_BY", P_BY, 1'b0, 3'd4, 1);
        hold("q_WG", P_WG, 1'b0, 3'd5, 2);
        hold("q_WR", P_WR, 1'b0, 3'd6, 11);
        hold("q_AG", P_AG, 1'b0, 3'd1, 3);
        check_eq("seq_pre", 32'(fault), 32'd0);
        drive(P_BG, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("seq_fault", 32'(fault), 32'd1);
        check_eq("seq_code", 32'(fault_code), 32'd3);
        hold("seq_BG", P_BG, 1'b0, 3'd3, 3);
        pulse_clear("seq_clr");

        // Maintenance flash from B_G, dark gap, back to A_G
        for (int i = 0; i < 3; i++) begin
            hold("m_red", P_RED, 1'b1, 3'd7, 1);
            hold("m_dark", P_DARK, 1'b1, 3'd7, 1);
        end
        hold("m_gap", P_DARK, 1'b0, 3'd7, 2);
        hold("m_AG", P_AG, 1'b0, 3'd1, 3);
        check_eq("maint_fault", 32'(fault), 32'd0);

        // Stuck in A_G
        hold("st_AG", P_AG, 1'b0, 3'd1, 28);
        @(negedge clk);
        check_eq("stuck_dwell31", 32'(dwell), 32'd31);
        check_eq("stuck_pre", 32'(fault), 32'd0);
        hold("st_AG2", P_AG, 1'b0, 3'd1, 1);
        @(negedge clk);
        check_eq("stuck_dwell32", 32'(dwell), 32'd32);
        check_eq("stuck_fault", 32'(fault), 32'd1);
        check_eq("stuck_code", 32'(fault_code), 32'd5);
        pulse_clear("stuck_clr");
        repeat (2) @(negedge clk);
        check_eq("stuck_noref", 32'(fault), 32'd0);
        check_eq("done_total", 32'(n_done), 32'd5);

        // Reset mid-phase after re-faulting
        drive(P_CONF, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("pre_rst_fault", 32'(fault), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_fault", 32'(fault), 32'd0);
        check_eq("mid_rst_code", 32'(fault_code), 32'd0);
        check_eq("mid_rst_ff", 32'(bus.force_flash), 32'd0);
        check_eq("mid_rst_phase", 32'(phase), 32'd0);
        check_eq("mid_rst_dwell", 32'(dwell), 32'd0);
        check_eq("mid_rst_done", 32'(cycle_done), 32'd0);
        reset = 1'b0;
        drive(P_AG, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Independent conflict/sequence monitor sitting on the lamp outputs of the intersection controller. It is the receiving end of the lamp bus.
- Registers the eight lamp lines plus MAINT and tick, then decodes the lit pattern into a phase.
- Checks for conflicting greens, illegal patterns, out-of-order phases and dwell-time violations.
- Latches a sticky fault that drives force_flash back to the controller/board.

Parameters:
- MIN_A_G, 3, minimum ticks in A green
- MIN_A_Y, 2, minimum ticks in A yellow
- MIN_B_G, 3, minimum ticks in B green
- MIN_B_Y, 1, minimum ticks in B yellow
- MIN_W_G, 2, minimum ticks in walk green
- MIN_W_R, 11, minimum ticks in walk clearance (flash plus solid red combined)
- MAX_DWELL_T, 32, watchdog limit in ticks for any non-maintenance phase

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- tick  in  1  one-clk pulse from the controller's tick generator
- MAINT  in  1  maintenance request, same signal the controller sees
- Ga,Ya,Ra,Gb,Yb,Rb,Gw,Rw  in  1 each  lamp lines
- clear_fault  in  1  one-clk pulse; clears a latched fault
- fault  out  1  sticky fault flag
- fault_code  out  3  first fault cause
- force_flash  out  1  equals fault; request for all-red flash
- phase  out  3  current decoded phase
- dwell  out  8  ticks counted in current phase, saturating at 255
- cycle_done  out  1  one-clk pulse on a legal W_R to A_G transition

Behaviour:
- Reset values: all outputs 0; phase = PH_NONE; internal first_phase = 1.
- Stage 1: lamps, MAINT and tick are registered every clk (lamps_q, maint_q, tick_q).
- Stage 2: decode and checks are combinational on the stage-1 registers; fault, phase, dwell and cycle_done are registered. Latency from input pins to fault is 2 clk.
- Decode rules, where goA = Ga|Ya, goB = Gb|Yb:
  - maint_q=1: PH_MAINT if no G/Y lamp is lit, else illegal.
  - A_G = {Ga,Rb,Rw} only; A_Y = {Ya,Rb,Rw}; B_G = {Ra,Gb,Rw}; B_Y = {Ra,Yb,Rw}; W_G = {Ra,Rb,Gw}.
  - W_R = {Ra,Rb}, Rw either value.
  - All lamps dark with maint_q=0: PH_MAINT (post-maintenance gap).
  - Any other pattern is illegal.
- Conflict: more than one of goA, goB, Gw set. This takes precedence over illegal.
- Legal transitions, checked when the decoded phase differs from phase:
  - A_G -> A_Y -> B_G -> B_Y -> W_G -> W_R -> A_G.
  - any phase -> PH_MAINT.
  - PH_MAINT -> A_G.
  - PH_NONE -> any phase.
  - Anything else is a sequence fault.
- Dwell counting:
  - dwell resets to 0 on a phase change.
  - Otherwise dwell increments when tick_q=1 and saturates at 255.
  - A tick registered together with the last old-phase sample is counted in the old phase.
- Short dwell: on leaving a non-MAINT phase, dwell < MIN_x gives a fault. The check is skipped while first_phase=1; first_phase clears on the first phase change.
- Stuck: in a non-MAINT, non-NONE phase, dwell reaching MAX_DWELL_T gives a fault.
- Fault codes: 1 conflict, 2 illegal, 3 sequence, 4 short dwell, 5 stuck. When several occur in the same cycle, priority is 1 > 2 > 3 > 4 > 5.
- Fault latch:
  - The first fault sets fault=1 and latches fault_code; later faults do not overwrite the code.
  - Phase and dwell tracking continue while faulted.
  - clear_fault zeroes fault and code.
  - clear_fault in the same cycle as a new fault: the new fault wins (fault=1, new code).
- cycle_done pulses only on a legal W_R -> A_G transition, regardless of fault state.
- Reset asserted mid-operation returns every register to its reset value on the next edge.

Decomposition:
- Package tlm_pkg holds:
  - phase localparams: PH_NONE=0, A_G=1, A_Y=2, B_G=3, B_Y=4, W_G=5, W_R=6, PH_MAINT=7
  - fault-code localparams FC_NONE..FC_STUCK
- Sub-module tlm_lamp_decode (combinational): takes the lamp vector and maint_q, returns phase, illegal and conflict.
- Sequencing, counters and the fault latch live in the top module.

Test Plan:
- Legal cycle, ticks every 4 clk with default dwell 3,2,3,1,2,11: no fault over 3 cycles; cycle_done pulses exactly once per 22 ticks; phase follows 1..6.
- Ga=Gb=1 held for 1 clk: fault=1, fault_code=1, force_flash=1 two clk later; fault stays set.
- A_G held 2 ticks then A_Y (not the first phase): fault_code=4 on the cycle after A_Y decodes.
- A_G followed directly by B_G pattern: fault_code=3.
- MAINT=1 during B_G, red flash with dark halves for 6 ticks, MAINT=0, dark gap, then A_G: no fault; phase goes 3 -> 7 -> 1.
- A_G held 32 ticks: fault_code=5. Then clear_fault pulse gives fault=0. Then reset mid-phase gives all outputs 0 and phase=0 the next clk.
